// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_LOCKUP  = 2'd2
    } exc_state_t;

    localparam logic [3:0]  ESTAT_NONE          = 4'b0000;
    localparam logic [3:0]  ESTAT_EXTIRQ        = 4'b0001;
    localparam logic [3:0]  ESTAT_NOTINSTR      = 4'b0010;
    localparam logic [63:0] EXC_VECTOR_DEFAULT  = 64'h0000_0000_0000_00D8;

    // Increment that sticks at the top of the 8-bit range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle between the decoder/fetch side (master) and exc_ctrl (slave).
//
// Interrupt handshake: a source raises irq_req[i] and holds it (level) until
// it sees irq_ack[i], a one-cycle pulse; it must drop irq_req[i] by the clock
// edge that ends the ack cycle. Exc/ERet are single-cycle decoder strobes with
// no back-pressure: exc_redirect / eret_redirect answer in the same cycle.
interface exc_ctrl_if #(
    parameter int N_IRQ = 4
);
    import exc_pkg::*;

    logic [N_IRQ-1:0] irq_req;
    logic [N_IRQ-1:0] irq_en;
    logic             Exc;
    logic [3:0]       EStatus;
    logic             ERet;
    logic [63:0]      pc_exc;

    logic             ExtIRQ;
    logic             exc_redirect;
    logic [63:0]      exc_vector;
    logic             eret_redirect;
    logic [63:0]      elr;
    logic [3:0]       esr;
    logic [N_IRQ-1:0] irq_ack;
    logic [2:0]       irq_id;
    logic             in_handler;
    logic             lockup;
    logic [7:0]       exc_count;
    exc_state_t       state_dbg;

    modport slave (
        input  irq_req, irq_en, Exc, EStatus, ERet, pc_exc,
        output ExtIRQ, exc_redirect, exc_vector, eret_redirect, elr, esr,
               irq_ack, irq_id, in_handler, lockup, exc_count, state_dbg
    );

    modport master (
        output irq_req, irq_en, Exc, EStatus, ERet, pc_exc,
        input  ExtIRQ, exc_redirect, exc_vector, eret_redirect, elr, esr,
               irq_ack, irq_id, in_handler, lockup, exc_count, state_dbg
    );

endinterface

// File: rtl/exc_ctrl_irq_prio_enc.sv
// Lowest-index-wins priority encoder over the pending interrupt lines.
module irq_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [2:0]   idx_o,
    output logic [N-1:0] onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid_o  = |req_i;
        idx_o    = '0;
        onehot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o       = 3'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: captures ELR/ESR, redirects fetch to the
// vector on accept, acknowledges the serviced IRQ and returns on ERET.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          N_IRQ       = 4,
    parameter logic [63:0] VECTOR_ADDR = EXC_VECTOR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    exc_ctrl_if.slave  bus
);

    exc_state_t       state_q, state_d;
    logic [N_IRQ-1:0] irq_pend_q;
    logic [63:0]      elr_q;
    logic [3:0]       esr_q;
    logic [N_IRQ-1:0] irq_ack_q;
    logic [2:0]       irq_id_q;
    logic [7:0]       exc_count_q;

    logic             pend_valid;
    logic [2:0]       pend_idx;
    logic [N_IRQ-1:0] pend_onehot;
    logic             accept;

    irq_prio_enc #(.N(N_IRQ)) u_prio (
        .req_i    (irq_pend_q),
        .valid_o  (pend_valid),
        .idx_o    (pend_idx),
        .onehot_o (pend_onehot)
    );

    // Only RUN takes new exceptions; a second one in HANDLER is a double fault.
    assign accept = (state_q == ST_RUN) && bus.Exc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // Next-state logic; Exc outranks ERet in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:     if (bus.Exc)       state_d = ST_HANDLER;
            ST_HANDLER: if (bus.Exc)       state_d = ST_LOCKUP;
                        else if (bus.ERet) state_d = ST_RUN;
            ST_LOCKUP:                     state_d = ST_LOCKUP;
            default:                       state_d = ST_RUN;
        endcase
    end

    // Decoded outputs: redirects are combinational from state plus decoder strobes.
    always_comb begin
        bus.ExtIRQ        = (state_q == ST_RUN) && (|irq_pend_q);
        bus.exc_redirect  = accept;
        bus.eret_redirect = (state_q == ST_HANDLER) && bus.ERet && !bus.Exc;
        bus.in_handler    = (state_q == ST_HANDLER);
        bus.lockup        = (state_q == ST_LOCKUP);
        bus.state_dbg     = state_q;
    end

    // Exception context capture, interrupt acknowledge and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_pend_q  <= '0;
            elr_q       <= '0;
            esr_q       <= '0;
            irq_ack_q   <= '0;
            irq_id_q    <= '0;
            exc_count_q <= '0;
        end else begin
            irq_pend_q <= bus.irq_req & bus.irq_en;
            irq_ack_q  <= '0;
            if (accept) begin
                elr_q       <= bus.pc_exc;
                esr_q       <= bus.EStatus;
                exc_count_q <= sat_inc8(exc_count_q);
                if ((bus.EStatus == ESTAT_EXTIRQ) && pend_valid) begin
                    irq_id_q  <= pend_idx;
                    irq_ack_q <= pend_onehot;
                end
            end
        end
    end

    assign bus.exc_vector = VECTOR_ADDR;
    assign bus.elr        = elr_q;
    assign bus.esr        = esr_q;
    assign bus.irq_ack    = irq_ack_q;
    assign bus.irq_id     = irq_id_q;
    assign bus.exc_count  = exc_count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: per-cycle stimulus with expected
// output snapshots queued alongside, compared at the falling edge.
module tb_exc_ctrl;
    import exc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    exc_ctrl_if #(.N_IRQ(4)) bus ();

    exc_ctrl #(.N_IRQ(4), .VECTOR_ADDR(64'h0000_0000_0000_00D8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard state ----------------
    // Snapshot layout: {ExtIRQ, exc_redirect, eret_redirect, in_handler, lockup,
    //                   irq_ack[3:0], irq_id[2:0], esr[3:0], exc_count[7:0], elr[63:0]}
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  en;
        logic        exc;
        logic [3:0]  est;
        logic        eret;
        logic [63:0] pc;
    } stim_t;

    stim_t       stim_q[$];
    logic [87:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] last_pc;

    function automatic logic [87:0] mk(input logic ext, input logic er, input logic rr,
                                       input logic inh, input logic lk,
                                       input logic [3:0] ack, input logic [2:0] id,
                                       input logic [3:0] es, input logic [7:0] cnt,
                                       input logic [63:0] el);
        return {ext, er, rr, inh, lk, ack, id, es, cnt, el};
    endfunction

    function automatic logic [87:0] snap();
        return {bus.ExtIRQ, bus.exc_redirect, bus.eret_redirect, bus.in_handler, bus.lockup,
                bus.irq_ack, bus.irq_id, bus.esr, bus.exc_count, bus.elr};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push(input logic rst, input logic [3:0] req, input logic [3:0] en,
                        input logic exc, input logic [3:0] est, input logic eret,
                        input logic [63:0] pc, input logic [87:0] expv);
        stim_t s;
        s.rst = rst; s.req = req; s.en = en; s.exc = exc;
        s.est = est; s.eret = eret; s.pc = pc;
        stim_q.push_back(s);
        exp_q.push_back(expv);
    endtask

    task automatic apply(input stim_t s);
        reset       = s.rst;
        bus.irq_req = s.req;
        bus.irq_en  = s.en;
        bus.Exc     = s.exc;
        bus.EStatus = s.est;
        bus.ERet    = s.eret;
        bus.pc_exc  = s.pc;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        stim_t s;
        logic [87:0] got, want;
        int k = 0;
        s = '{1'b1, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 64'h0};
        apply(s);
        repeat (2) @(posedge clk);
        #1;
        push(0, 4'h0, 4'h0, 0, 4'h0, 0, 64'h0, mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset[%0d]: got %h want %h", k, got, want);
            end
            n_vec++;
            if (bus.exc_vector !== 64'h0000_0000_0000_00D8) begin
                n_err++;
                $display("FAIL exc_vector: got %h want %h", bus.exc_vector, 64'hD8);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_irq_accept_eret();
        logic [87:0] got, want;
        int k = 0;
        push(0, 4'b0110, 4'hF, 0, 4'h0, 0, 64'h0,  mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        push(0, 4'b0110, 4'hF, 0, 4'h0, 0, 64'h0,  mk(1,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        push(0, 4'b0110, 4'hF, 1, 4'h1, 0, 64'h40, mk(1,1,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        // ack cycle, line 1 dropped, one-cycle handler returns immediately
        push(0, 4'b0100, 4'hF, 0, 4'h0, 1, 64'h0,  mk(0,0,1,1,0,4'b0010,3'd1,4'h1,8'd1,64'h40));
        push(0, 4'b0000, 4'hF, 0, 4'h0, 0, 64'h0,  mk(1,0,0,0,0,4'h0,3'd1,4'h1,8'd1,64'h40));
        push(0, 4'b0000, 4'hF, 0, 4'h0, 0, 64'h0,  mk(0,0,0,0,0,4'h0,3'd1,4'h1,8'd1,64'h40));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL irq_accept_eret[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lockup();
        logic [87:0] got, want;
        int k = 0;
        push(0, 4'h0, 4'hF, 1, 4'h2, 0, 64'h88, mk(0,1,0,0,0,4'h0,3'd1,4'h1,8'd1,64'h40));
        push(0, 4'h0, 4'hF, 1, 4'h2, 0, 64'hC0, mk(0,0,0,1,0,4'h0,3'd1,4'h2,8'd2,64'h88));
        push(0, 4'h0, 4'hF, 0, 4'h0, 1, 64'h0,  mk(0,0,0,0,1,4'h0,3'd1,4'h2,8'd2,64'h88));
        push(0, 4'hF, 4'hF, 1, 4'h1, 0, 64'h0,  mk(0,0,0,0,1,4'h0,3'd1,4'h2,8'd2,64'h88));
        push(0, 4'hF, 4'hF, 0, 4'h0, 1, 64'h0,  mk(0,0,0,0,1,4'h0,3'd1,4'h2,8'd2,64'h88));
        push(1, 4'h0, 4'hF, 0, 4'h0, 0, 64'h0,  mk(0,0,0,0,1,4'h0,3'd1,4'h2,8'd2,64'h88));
        push(0, 4'h0, 4'hF, 0, 4'h0, 0, 64'h0,  mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL lockup[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_eret_in_run();
        logic [87:0] got, want;
        int k = 0;
        push(0, 4'h0,    4'hF, 0, 4'h0, 1, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        push(0, 4'h0,    4'hF, 1, 4'h0, 1, 64'h100, mk(0,1,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        push(0, 4'h0,    4'hF, 0, 4'h0, 1, 64'h0,   mk(0,0,1,1,0,4'h0,3'd0,4'h0,8'd1,64'h100));
        push(0, 4'b0001, 4'hF, 0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd1,64'h100));
        // unknown cause code with a pending line: captured verbatim, no ack
        push(0, 4'b0001, 4'hF, 1, 4'hA, 0, 64'h200, mk(1,1,0,0,0,4'h0,3'd0,4'h0,8'd1,64'h100));
        push(0, 4'h0,    4'hF, 0, 4'h0, 1, 64'h0,   mk(0,0,1,1,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        push(0, 4'h0,    4'hF, 0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL eret_in_run[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_irq_disable();
        logic [87:0] got, want;
        int k = 0;
        push(0, 4'hF, 4'h0,    0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        push(0, 4'hF, 4'h0,    0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        push(0, 4'hF, 4'b1000, 0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        push(0, 4'hF, 4'b1000, 1, 4'h1, 0, 64'h300, mk(1,1,0,0,0,4'h0,3'd0,4'hA,8'd2,64'h200));
        push(0, 4'h0, 4'b1000, 0, 4'h0, 1, 64'h0,   mk(0,0,1,1,0,4'b1000,3'd3,4'h1,8'd3,64'h300));
        push(0, 4'h0, 4'hF,    0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd3,4'h1,8'd3,64'h300));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL irq_disable[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [87:0] got, want;
        logic [7:0]  cnt  = 8'd3;
        logic [3:0]  es_m = 4'h1;
        logic [63:0] el_m = 64'h300;
        logic [63:0] pc;
        int k = 0;
        // ESTAT_EXTIRQ with nothing pending: id held, no ack
        for (int i = 0; i < 256; i++) begin
            pc = 64'($urandom_range(1, 32'hFFFF)) << 2;
            push(0, 4'h0, 4'hF, 1, ESTAT_EXTIRQ, 0, pc, mk(0,1,0,0,0,4'h0,3'd3,es_m,cnt,el_m));
            cnt  = (cnt == 8'd255) ? cnt : cnt + 8'd1;
            es_m = ESTAT_EXTIRQ;
            el_m = pc;
            push(0, 4'h0, 4'hF, 0, 4'h0, 1, 64'h0, mk(0,0,1,1,0,4'h0,3'd3,es_m,cnt,el_m));
        end
        push(0, 4'h0, 4'hF, 0, 4'h0, 0, 64'h0, mk(0,0,0,0,0,4'h0,3'd3,4'h1,8'd255,el_m));
        last_pc = el_m;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_ack();
        logic [87:0] got, want;
        int k = 0;
        push(0, 4'b0100, 4'hF, 0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd3,4'h1,8'd255,last_pc));
        push(0, 4'b0100, 4'hF, 1, 4'h1, 0, 64'h500, mk(1,1,0,0,0,4'h0,3'd3,4'h1,8'd255,last_pc));
        push(1, 4'h0,    4'hF, 0, 4'h0, 0, 64'h0,   mk(0,0,0,1,0,4'b0100,3'd2,4'h1,8'd255,64'h500));
        push(0, 4'h0,    4'hF, 0, 4'h0, 0, 64'h0,   mk(0,0,0,0,0,4'h0,3'd0,4'h0,8'd0,64'h0));
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front());
            @(negedge clk);
            got = snap(); want = exp_q.pop_front(); n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_in_ack[%0d]: got %h want %h", k, got, want);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_irq_accept_eret();
        test_lockup();
        test_eret_in_run();
        test_irq_disable();
        test_back_to_back();
        test_reset_in_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
